// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset
//            sharing one handshaked memory port, with access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       negative,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_sel,
  output logic       lui_op,
  output logic       instret,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int c_wait_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [4:0] c_op_load   = 5'b00000;
  localparam logic [4:0] c_op_opimm  = 5'b00100;
  localparam logic [4:0] c_op_store  = 5'b01000;
  localparam logic [4:0] c_op_op     = 5'b01100;
  localparam logic [4:0] c_op_lui    = 5'b01101;
  localparam logic [4:0] c_op_branch = 5'b11000;
  localparam logic [4:0] c_op_jal    = 5'b11011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_JAL    = 4'd9,
    S_LUI    = 4'd10,
    S_BRANCH = 4'd11,
    S_FAULT  = 4'd12
  } state_e;

  state_e              state_q, state_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic                w_wait_state;
  logic                w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // A ready on the limit cycle takes priority over the timeout.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
                     (wait_q == c_wait_w'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 1'b0;
    result_src = 2'b00;
    instret    = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    lui_op     = (opcode == c_op_lui);
    state      = state_q;

    case (opcode)
      c_op_store:  imm_sel = 2'b01;
      c_op_branch: imm_sel = 2'b10;
      c_op_jal:    imm_sel = 2'b11;
      default:     imm_sel = 2'b00;
    endcase

    // The counter is zero everywhere except while waiting, so every entry starts clean.
    if (w_wait_state && !mem_ready && !w_timeout) begin
      wait_d = wait_q + c_wait_w'(1);
    end

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        if (w_timeout) begin
          mem_read = 1'b0;
          bus_err  = 1'b1;
          state_d  = S_FAULT;
        end else if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          result_src = 2'b10;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          c_op_load, c_op_store: state_d = S_MEMADR;
          c_op_op:               state_d = S_EXECR;
          c_op_opimm:            state_d = S_EXECI;
          c_op_lui:              state_d = S_LUI;
          c_op_jal:              state_d = S_JAL;
          c_op_branch:           state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FAULT;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == c_op_store) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (w_timeout) begin
          mem_read = 1'b0;
          bus_err  = 1'b1;
          state_d  = S_FAULT;
        end else if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        instret    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (w_timeout) begin
          mem_write = 1'b0;
          bus_err   = 1'b1;
          state_d   = S_FAULT;
        end else if (mem_ready) begin
          instret = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        instret   = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; ALUWB then writes OldPC+4 to rd.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        reg_write  = 1'b1;
        result_src = 2'b11;
        instret    = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 1'b1;
        pc_write  = negative;
        instret   = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 1'b0;
      result_src = 2'b00;
      imm_sel    = 2'b00;
      lui_op     = 1'b0;
      instret    = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      state      = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Plan-driven bench: each instruction is expanded into an expected
//            per-cycle trace (inputs + outputs) and replayed against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMRD = 4'd3,  ST_MEMWB  = 4'd4, ST_MEMWR  = 4'd5,
                         ST_EXECR = 4'd6,  ST_EXECI  = 4'd7, ST_ALUWB  = 4'd8,
                         ST_JAL   = 4'd9,  ST_LUI    = 4'd10, ST_BRANCH = 4'd11,
                         ST_FAULT = 4'd12;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_OPIMM = 5'b00100, OP_STORE = 5'b01000,
                         OP_OP = 5'b01100, OP_LUI = 5'b01101, OP_BRANCH = 5'b11000,
                         OP_JAL = 5'b11011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       negative;
  logic       mem_ready;
  logic       ir_write, pc_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_sel;
  logic       alu_op, lui_op, instret, illegal, bus_err;
  logic [3:0] state;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .negative(negative), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_sel(imm_sel),
    .lui_op(lui_op), .instret(instret), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mr;
    logic        neg;
    logic [4:0]  op;
    logic [3:0]  st;
    logic [18:0] outs;
  } cyc_t;

  cyc_t       plan[$];
  logic [4:0] cur_op;
  int         n_total = 0;
  int         n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [18:0] dut_outs();
    return {ir_write, pc_write, adr_src, mem_read, mem_write, reg_write, alu_src_a,
            alu_src_b, alu_op, result_src, imm_sel, lui_op, instret, illegal, bus_err};
  endfunction

  // Expected output vector; immediate select and LUI flag follow the opcode in every state.
  function automatic logic [18:0] ex(input logic ir, pcw, adr, mrd, mwr, rw,
                                     input logic [1:0] sa, sb, input logic aop,
                                     input logic [1:0] rs, input logic ret, ill, be);
    logic [1:0] imm;
    imm = (cur_op == OP_STORE) ? 2'b01 : (cur_op == OP_BRANCH) ? 2'b10 :
          (cur_op == OP_JAL) ? 2'b11 : 2'b00;
    return {ir, pcw, adr, mrd, mwr, rw, sa, sb, aop, rs, imm, (cur_op == OP_LUI), ret, ill, be};
  endfunction

  function automatic logic [18:0] idle_outs();
    return ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic neg, input logic [18:0] o);
    cyc_t c;
    c.mr = mr; c.neg = neg; c.op = cur_op; c.st = st; c.outs = o;
    plan.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One memory access that completes after `lat` not-ready cycles, or times out.
  task automatic plan_access(input logic [3:0] st, input int lat, output bit ok);
    logic       is_f, adr, mrd, mwr;
    logic [1:0] sb;
    is_f = (st == ST_FETCH);
    adr  = !is_f;
    mrd  = (st != ST_MEMWR);
    mwr  = (st == ST_MEMWR);
    sb   = is_f ? 2'b10 : 2'b00;
    ok   = 1'b1;
    for (int k = 0; k <= TIMEOUT; k++) begin
      if (k == lat) begin
        push(st, 1'b1, rb(), ex(is_f, is_f, adr, mrd, mwr, 0, 2'b00, sb, 0,
                                is_f ? 2'b10 : 2'b00, mwr, 0, 0));
        break;
      end else if (k == TIMEOUT) begin
        push(st, 1'b0, rb(), ex(0, 0, adr, 0, 0, 0, 2'b00, sb, 0, 2'b00, 0, 0, 1));
        push(ST_FAULT, rb(), rb(), idle_outs());
        ok = 1'b0;
        break;
      end else begin
        push(st, 1'b0, rb(), ex(0, 0, adr, mrd, mwr, 0, 2'b00, sb, 0, 2'b00, 0, 0, 0));
      end
    end
  endtask

  task automatic plan_instr(input logic [4:0] op, input int lat_f, input int lat_m, input logic neg);
    bit   ok;
    logic legal;
    cur_op = op;
    plan_access(ST_FETCH, lat_f, ok);
    if (!ok) return;
    legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_OP) || (op == OP_OPIMM) ||
            (op == OP_LUI) || (op == OP_JAL) || (op == OP_BRANCH);
    push(ST_DECODE, rb(), rb(), ex(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 2'b00, 0, !legal, 0));
    if (!legal) begin
      push(ST_FAULT, rb(), rb(), idle_outs());
      return;
    end
    case (op)
      OP_LOAD, OP_STORE: begin
        push(ST_MEMADR, rb(), rb(), ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 2'b00, 0, 0, 0));
        plan_access((op == OP_LOAD) ? ST_MEMRD : ST_MEMWR, lat_m, ok);
        if (ok && op == OP_LOAD)
          push(ST_MEMWB, rb(), rb(), ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b01, 1, 0, 0));
      end
      OP_OP, OP_OPIMM: begin
        if (op == OP_OP)
          push(ST_EXECR, rb(), rb(), ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b00, 0, 0, 0));
        else
          push(ST_EXECI, rb(), rb(), ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 2'b00, 0, 0, 0));
        push(ST_ALUWB, rb(), rb(), ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0));
      end
      OP_LUI: push(ST_LUI, rb(), rb(), ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b11, 1, 0, 0));
      OP_JAL: begin
        push(ST_JAL, rb(), rb(), ex(0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 2'b00, 0, 0, 0));
        push(ST_ALUWB, rb(), rb(), ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0));
      end
      default: push(ST_BRANCH, rb(), neg, ex(0, neg, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b00, 1, 0, 0));
    endcase
  endtask

  // Entered and left at posedge+1; outputs are sampled at the following negedge.
  task automatic run_plan(input int max_cycles);
    cyc_t c;
    for (int n = 0; n < max_cycles && plan.size() > 0; n++) begin
      c = plan.pop_front();
      opcode = c.op; mem_ready = c.mr; negative = c.neg;
      @(negedge clk);
      check_val("state", {28'd0, state}, {28'd0, c.st});
      check_val("outs", {13'd0, dut_outs()}, {13'd0, c.outs});
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r < 8) return TIMEOUT;
    return TIMEOUT + 5;
  endfunction

  logic [4:0] legal_ops[7] = '{OP_LOAD, OP_OPIMM, OP_STORE, OP_OP, OP_LUI, OP_BRANCH, OP_JAL};

  initial begin
    logic [4:0] op;
    rst = 1'b1; opcode = OP_LUI; negative = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_val("rst_outs", {13'd0, dut_outs()}, 32'd0);
    check_val("rst_state", {28'd0, state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    plan_instr(OP_OPIMM, 0, 0, 0);
    plan_instr(OP_LOAD, 0, 3, 0);
    plan_instr(OP_BRANCH, 0, 0, 1);
    plan_instr(OP_BRANCH, 0, 0, 0);
    plan_instr(5'b11111, 0, 0, 0);
    plan_instr(OP_OP, TIMEOUT + 3, 0, 0);
    plan_instr(OP_JAL, TIMEOUT, 0, 0);
    plan_instr(OP_STORE, 1, TIMEOUT + 1, 0);
    plan_instr(OP_LOAD, 2, TIMEOUT, 0);
    plan_instr(OP_LUI, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 7) ? 5'($urandom) : legal_ops[$urandom_range(0, 6)];
      plan_instr(op, rand_lat(), rand_lat(), rb());
    end
    run_plan(100000);

    // Reset in the middle of a store wait: FETCH, DECODE, MEMADR, two MEMWR waits.
    plan_instr(OP_STORE, 0, TIMEOUT + 5, 0);
    run_plan(5);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst_mid_mem_write", {31'd0, mem_write}, 32'd0);
    check_val("rst_mid_outs", {13'd0, dut_outs()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cur_op = OP_STORE;
    check_val("post_rst_state", {28'd0, state}, {28'd0, ST_FETCH});
    check_val("post_rst_outs", {13'd0, dut_outs()},
              {13'd0, ex(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 0)});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
